pwm_ramp_ctrl: RTL
==================

// Module: pwm_ramp_ctrl
// PURPOSE
//   Configures and sequences one PWM channel (period/duty/enable, counter fed back).
//   Accepts a validated config over a valid/ready handshake and soft-starts duty from 1 to target.
//   Duty and period change only at PWM period boundaries; stop ramps duty back down before disabling.
//   Sits between the register/control layer and the PWM block; it owns io_en/io_periodCounter/io_dutyCicle.
// PARAMETERS
//   W                 8   width of period, duty, step and counter
//   PERIODS_PER_STEP  4   PWM periods between duty ramp steps (>=1)
// PORTS
//   clock             in   1  single clock, all state on rising edge
//   reset             in   1  asynchronous, active-low (0 = reset)
//   io_cfgValid       in   1  config offer
//   io_cfgReady       out  1  config accepted when valid&ready
//   io_cfgPeriod      in   W  requested PWM period
//   io_cfgDuty        in   W  requested target duty
//   io_cfgStep        in   W  duty increment/decrement per ramp step
//   io_cfgErr         out  1  1-cycle pulse: accepted config was invalid and discarded
//   io_start          in   1  start request (level sampled each cycle)
//   io_stop           in   1  stop request (level sampled each cycle)
//   io_contador       in   W  PWM counter feedback
//   io_en             out  1  PWM enable
//   io_periodCounter  out  W  PWM period
//   io_dutyCicle      out  W  PWM duty
//   io_busy           out  1  1 in any state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE, io_en=0, io_periodCounter=2, io_dutyCicle=1, io_cfgErr=0; shadow period=2,
//     target=1, step=1, cfgLoaded=0, step counter=0. Async assert clears mid-operation at once.
//   Invariant, every cycle: 0 < io_dutyCicle < io_periodCounter.
//   boundary = io_en && (io_contador == io_periodCounter). All updates below registered (+1 cycle).
//   io_cfgReady = 1 in IDLE and HOLD, 0 in RAMP and DRAIN.
//   Config valid iff period>0, duty>0, duty<period, step>0. Valid: shadow regs load, cfgLoaded=1.
//     Invalid: shadow unchanged, io_cfgErr pulses next cycle; handshake still completes.
//   States:
//   IDLE : io_en=0. start && !stop && cfgLoaded -> io_en=1, period=shadow, duty=1, RAMP.
//          start without cfgLoaded ignored; start&&stop same cycle -> stop wins.
//   RAMP : on boundary step counter++; at PERIODS_PER_STEP-1 (counter->0):
//          duty<target: duty=min(duty+step,target) computed W+1 bits (no wrap);
//          duty>target: duty=max(duty-step,target); duty==target after update -> HOLD.
//          stop -> DRAIN immediately (step counter kept).
//   HOLD : duty fixed. Accepted valid config marked pending; at next boundary:
//          period=new period, duty=min(duty,new period-1), target=new duty, -> RAMP (HOLD if equal).
//          stop -> DRAIN (pending config dropped). start ignored.
//   DRAIN: target forced to 1, ramps down as RAMP; on step boundary with duty==1 ->
//          io_en=0, IDLE (shadow/cfgLoaded kept). start ignored.
//   Config+boundary same cycle in HOLD: new config applies at the following boundary.
//   step>=|duty-target|: single step lands exactly on target. PERIODS_PER_STEP=1: every boundary.
// CONFIGURATION
//   PWM_CTRL_SOFTSTOP_EN defined: stop behaves as above (DRAIN ramp-down).
//   Not defined: DRAIN not built; stop in RAMP/HOLD -> io_en=0, duty=1, IDLE at next
//     boundary (or at once if io_en=0); outputs otherwise identical.
// TESTING
//   Reset low mid-RAMP -> same cycle io_en=0, period=2, duty=1, io_busy=0.
//   cfg P=10,D=7,S=3, start, PPS=4 -> duty 1,4,7 each after 4 boundaries, then HOLD, busy=1.
//   cfg P=5,D=5,S=1 -> io_cfgErr one pulse, shadow unchanged; start w/o prior valid cfg -> stays IDLE.
//   HOLD P=10,D=7; cfg P=6,D=2,S=2 -> at boundary period=6, duty=5, then 3, 2 -> HOLD.
//   stop in HOLD D=7,S=3 (SOFTSTOP_EN) -> duty 4,1 then io_en=0, IDLE; without macro -> io_en=0 next boundary.
//   start&&stop same cycle in IDLE -> no enable; io_cfgValid in RAMP -> io_cfgReady=0, not taken.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for one PWM channel: takes a validated config over valid/ready, soft-starts the duty, and changes duty/period only on PWM period boundaries.
// Optional build macro PWM_CTRL_SOFTSTOP_EN: stop ramps the duty down (DRAIN) before disabling; otherwise stop disables at the next boundary.
module pwm_ramp_ctrl #(
    parameter int W                = 8,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_cfgValid,
    output logic         io_cfgReady,
    input  logic [W-1:0] io_cfgPeriod,
    input  logic [W-1:0] io_cfgDuty,
    input  logic [W-1:0] io_cfgStep,
    output logic         io_cfgErr,
    input  logic         io_start,
    input  logic         io_stop,
    input  logic [W-1:0] io_contador,
    output logic         io_en,
    output logic [W-1:0] io_periodCounter,
    output logic [W-1:0] io_dutyCicle,
    output logic         io_busy
);
    localparam int            CW        = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [CW-1:0] STEP_LAST = CW'(PERIODS_PER_STEP - 1);
    localparam logic [W-1:0]  ONE       = W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD
`ifdef PWM_CTRL_SOFTSTOP_EN
        , S_DRAIN
`endif
    } state_t;

    state_t        state;
    logic [W-1:0]  sh_period, sh_target, sh_step;
    logic          cfg_loaded, cfg_pending;
    logic [W-1:0]  target, step;
    logic [CW-1:0] step_cnt;
`ifndef PWM_CTRL_SOFTSTOP_EN
    logic          stop_pending;
`endif

    logic          boundary, step_due, cfg_fire, cfg_ok;
    logic [W:0]    up_sum, dn_floor;
    logic [W-1:0]  ramp_duty, sh_period_m1, clamp_duty;

    assign boundary     = io_en && (io_contador == io_periodCounter);
    assign step_due     = boundary && (step_cnt == STEP_LAST);
    assign io_cfgReady  = (state == S_IDLE) || (state == S_HOLD);
    assign io_busy      = (state != S_IDLE);
    assign cfg_fire     = io_cfgValid && io_cfgReady;
    assign cfg_ok       = (io_cfgPeriod != '0) && (io_cfgDuty != '0) &&
                          (io_cfgDuty < io_cfgPeriod) && (io_cfgStep != '0);
    assign sh_period_m1 = sh_period - ONE;
    assign clamp_duty   = (io_dutyCicle < sh_period_m1) ? io_dutyCicle : sh_period_m1;

    // Next ramp value toward target, computed one bit wider so it saturates instead of wrapping.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        up_sum    = {1'b0, io_dutyCicle} + {1'b0, step};
        dn_floor  = {1'b0, target} + {1'b0, step};
        ramp_duty = io_dutyCicle;
        if (io_dutyCicle < target)
            ramp_duty = (up_sum >= {1'b0, target}) ? target : up_sum[W-1:0];
        else if (io_dutyCicle > target)
            ramp_duty = ({1'b0, io_dutyCicle} >= dn_floor) ? (io_dutyCicle - step) : target;
    end

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            io_en            <= 1'b0;
            io_periodCounter <= W'(2);
            io_dutyCicle     <= ONE;
            io_cfgErr        <= 1'b0;
            sh_period        <= W'(2);
            sh_target        <= ONE;
            sh_step          <= ONE;
            cfg_loaded       <= 1'b0;
            cfg_pending      <= 1'b0;
            target           <= ONE;
            step             <= ONE;
            step_cnt         <= '0;
`ifndef PWM_CTRL_SOFTSTOP_EN
            stop_pending     <= 1'b0;
`endif
        end else begin
            io_cfgErr <= cfg_fire && !cfg_ok;
            case (state)
                S_IDLE: begin
                    if (io_start && !io_stop && cfg_loaded) begin
                        io_en            <= 1'b1;
                        io_periodCounter <= sh_period;
                        io_dutyCicle     <= ONE;
                        target           <= sh_target;
                        step             <= sh_step;
                        step_cnt         <= '0;
                        cfg_pending      <= 1'b0;
                        state            <= S_RAMP;
                    end
                end
                S_RAMP, S_HOLD: begin
`ifdef PWM_CTRL_SOFTSTOP_EN
                    if (io_stop) begin
                        target      <= ONE;
                        cfg_pending <= 1'b0;
                        state       <= S_DRAIN;
                    end else
`else
                    // A stop is remembered until the boundary where the channel shuts off.
                    if (io_stop || stop_pending) begin
                        if (boundary) begin
                            io_en        <= 1'b0;
                            io_dutyCicle <= ONE;
                            step_cnt     <= '0;
                            stop_pending <= 1'b0;
                            cfg_pending  <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            stop_pending <= 1'b1;
                        end
                    end else
`endif
                    if (state == S_RAMP) begin
                        if (step_due) begin
                            step_cnt     <= '0;
                            io_dutyCicle <= ramp_duty;
                            if (ramp_duty == target)
                                state <= S_HOLD;
                        end else if (boundary) begin
                            step_cnt <= step_cnt + CW'(1);
                        end
                    end else if (boundary && cfg_pending) begin
                        io_periodCounter <= sh_period;
                        io_dutyCicle     <= clamp_duty;
                        target           <= sh_target;
                        step             <= sh_step;
                        step_cnt         <= '0;
                        cfg_pending      <= 1'b0;
                        state            <= (clamp_duty == sh_target) ? S_HOLD : S_RAMP;
                    end
                end
`ifdef PWM_CTRL_SOFTSTOP_EN
                S_DRAIN: begin
                    if (step_due) begin
                        step_cnt <= '0;
                        if (io_dutyCicle == ONE) begin
                            io_en <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            io_dutyCicle <= ramp_duty;
                        end
                    end else if (boundary) begin
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase

            // Placed after the state case so a config taken while holding is not lost.
            if (cfg_fire && cfg_ok) begin
                sh_period  <= io_cfgPeriod;
                sh_target  <= io_cfgDuty;
                sh_step    <= io_cfgStep;
                cfg_loaded <= 1'b1;
                if (state == S_HOLD && !io_stop)
                    cfg_pending <= 1'b1;
            end
        end
    end
endmodule
